// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
//   Bundle of fetch, loader and BRAM-side signals around the instruction
//   memory arbiter.
//   slave  : arbiter side (takes requests and BRAM read data, drives grants,
//            returned data, BRAM address/we/wdata and the stall counter)
//   master : environment side (fetch unit, loader, BRAM)
interface imem_port_arbiter_if #(
  parameter int INST_DEPTH = 256
);
  localparam int AW = $clog2(INST_DEPTH);

  // fetch side
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  // loader / debug side
  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  // BRAM side
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  // status
  logic [31:0]   stall_cnt;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_addr, mem_we, mem_wdata, stall_cnt
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_addr, mem_we, mem_wdata, stall_cnt
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares the single synchronous-read port of the instruction BRAM between
//   the CPU fetch unit and the program loader / debug port. Fetch is favoured;
//   the loader wins after MAX_WAIT consecutive losing cycles and can hold the
//   port across a burst with l_lock. Read ownership is tracked for one cycle
//   so BRAM data is flagged valid to the requester that issued the read.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high
//     bus   : imem_port_arbiter_if.slave (fetch, loader, BRAM, stall_cnt)
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   FETCH_PRI | fetch favoured, loader protected by the wait counter
//   LOAD_LOCK | loader burst in progress, loader has absolute priority
module imem_port_arbiter #(
  parameter int INST_DEPTH = 256,
  parameter int MAX_WAIT   = 4
) (
  input logic                 clk,
  input logic                 reset,
  imem_port_arbiter_if.slave  bus
);
  localparam int         AW         = $clog2(INST_DEPTH);
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic       {FETCH_PRI, LOAD_LOCK}            state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD}   owner_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  owner_t        owner_q, owner_d;
  logic [31:0]   stall_q, stall_d;

  logic          f_gnt;
  logic          l_gnt;
  logic          locked;
  logic [AW-1:0] mem_addr_d;

  // Lock is sampled combinationally: the cycle l_lock drops is already
  // arbitrated with fetch-priority rules.
  always_comb begin
    f_gnt  = 1'b0;
    l_gnt  = 1'b0;
    locked = (state_q == LOAD_LOCK) && bus.l_lock;
    if (!reset) begin
      if (locked) begin
        l_gnt = bus.l_req;
        f_gnt = bus.f_req && !bus.l_req;
      end else if (bus.f_req && bus.l_req) begin
        if (wait_q == MAX_WAIT_C) l_gnt = 1'b1;
        else                      f_gnt = 1'b1;
      end else begin
        f_gnt = bus.f_req;
        l_gnt = bus.l_req;
      end
    end
  end

  always_comb begin
    state_d = (bus.l_lock && (locked || l_gnt)) ? LOAD_LOCK : FETCH_PRI;

    wait_d = 4'd0;
    if (bus.l_req && !l_gnt)
      wait_d = (wait_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_q + 4'd1;

    owner_d = OWN_NONE;
    if (f_gnt)                    owner_d = OWN_FETCH;
    else if (l_gnt && !bus.l_we)  owner_d = OWN_LOAD;

    stall_d = stall_q;
    if (bus.f_req && !f_gnt) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_PRI;
      wait_q  <= 4'd0;
      owner_q <= OWN_NONE;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      owner_q <= owner_d;
      stall_q <= stall_d;
    end
  end

  // With no grant the fetch address is presented so the port idles on it.
  assign mem_addr_d    = l_gnt ? bus.l_addr : bus.f_addr;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_we    = l_gnt && bus.l_we;
  assign bus.mem_wdata = bus.l_wdata;

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;

  // Gated with reset so a read in flight when reset hits never reports valid.
  assign bus.f_rvalid  = !reset && (owner_q == OWN_FETCH);
  assign bus.l_rvalid  = !reset && (owner_q == OWN_LOAD);
  assign bus.f_rdata   = bus.mem_rdata;
  assign bus.l_rdata   = bus.mem_rdata;

  assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  imem_port_arbiter_if #(.INST_DEPTH(256)) bus ();

  imem_port_arbiter #(.INST_DEPTH(256), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: registered read, write-first, word i preloaded with 0x1000_0000+i.
  logic [31:0] mem [256];
  bit          mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + 32'(k);
      mem_init <= 1'b1;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] exp_l;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
    bus.l_addr = '0;  bus.l_wdata = '0;

    // reset: grants, write enable and rvalids held low even with requests up
    @(negedge clk);
    @(negedge clk);
    bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_we = 1'b1;
    #1;
    chk1("rst_f_gnt", bus.f_gnt, 1'b0);
    chk1("rst_l_gnt", bus.l_gnt, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_f_rvalid", bus.f_rvalid, 1'b0);
    chk1("rst_l_rvalid", bus.l_rvalid, 1'b0);
    chk32("rst_stall", bus.stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0;

    // fetch only, addresses 0..7
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.f_req = 1'b1; bus.f_addr = 8'(i);
      #1;
      chk1("f1_f_gnt", bus.f_gnt, 1'b1);
      chk32("f1_mem_addr", 32'(bus.mem_addr), 32'(i));
      chk1("f1_mem_we", bus.mem_we, 1'b0);
      chk1("f1_f_rvalid", bus.f_rvalid, (i > 0));
      if (i > 0) chk32("f1_f_rdata", bus.f_rdata, 32'h1000_0000 + 32'(i - 1));
    end
    @(negedge clk);
    bus.f_req = 1'b0;
    #1;
    chk1("f1_idle_gnt", bus.f_gnt, 1'b0);
    chk1("f1_last_rvalid", bus.f_rvalid, 1'b1);
    chk32("f1_last_rdata", bus.f_rdata, 32'h1000_0007);
    chk32("f1_stall", bus.stall_cnt, 32'd0);

    // loader write 0xDEADBEEF to 5, then fetch reads it back
    @(negedge clk);
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 8'd5; bus.l_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("w_l_gnt", bus.l_gnt, 1'b1);
    chk1("w_f_gnt", bus.f_gnt, 1'b0);
    chk1("w_mem_we", bus.mem_we, 1'b1);
    chk32("w_mem_addr", 32'(bus.mem_addr), 32'd5);
    chk32("w_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 8'd5;
    #1;
    chk1("w_we_pulse_end", bus.mem_we, 1'b0);
    chk1("w_no_l_rvalid", bus.l_rvalid, 1'b0);
    chk1("w_f_gnt_rd", bus.f_gnt, 1'b1);
    @(negedge clk);
    bus.f_req = 1'b0;
    #1;
    chk1("w_f_rvalid", bus.f_rvalid, 1'b1);
    chk32("w_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);
    chk1("w_no_l_rvalid2", bus.l_rvalid, 1'b0);

    // both requesting, no lock: loader wins every 5th cycle
    exp_l = 15'b100001000010000;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      bus.f_req = 1'b1; bus.f_addr = 8'd20;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_lock = 1'b0; bus.l_addr = 8'd9;
      #1;
      chk1("s_l_gnt", bus.l_gnt, exp_l[c]);
      chk1("s_f_gnt", bus.f_gnt, !exp_l[c]);
      if (c == 5) begin
        chk1("s_l_rvalid", bus.l_rvalid, 1'b1);
        chk32("s_l_rdata", bus.l_rdata, 32'h1000_0009);
        chk1("s_f_rvalid_off", bus.f_rvalid, 1'b0);
      end
    end

    // locked burst: loader wins after the starvation bound, then holds 6 writes
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) chk32("s_stall", bus.stall_cnt, 32'd3);
      bus.f_req = 1'b1; bus.f_addr = 8'd20;
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
      bus.l_addr  = (c < 4) ? 8'd100 : 8'(100 + c - 4);
      bus.l_wdata = (c < 4) ? 32'hA000_0000 : 32'hA000_0000 + 32'(c - 4);
      #1;
      chk1("b_l_gnt", bus.l_gnt, (c >= 4));
      chk1("b_f_gnt", bus.f_gnt, (c < 4));
      chk1("b_mem_we", bus.mem_we, (c >= 4));
      if (c >= 4) chk32("b_mem_addr", 32'(bus.mem_addr), 32'(100 + c - 4));
    end
    @(negedge clk);
    bus.l_lock = 1'b0; bus.l_req = 1'b0; bus.f_addr = 8'd50;
    #1;
    chk32("b_stall", bus.stall_cnt, 32'd9);
    chk1("b_unlock_f_gnt", bus.f_gnt, 1'b1);
    chk1("b_unlock_l_gnt", bus.l_gnt, 1'b0);
    // both requesting right after the burst: fetch priority is back
    @(negedge clk);
    bus.f_addr = 8'd103;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'd3;
    #1;
    chk1("b_fpri_f_gnt", bus.f_gnt, 1'b1);
    chk1("b_fpri_l_gnt", bus.l_gnt, 1'b0);

    // loader read of addr 3
    @(negedge clk);
    bus.f_req = 1'b0;
    #1;
    chk1("r_f_rvalid", bus.f_rvalid, 1'b1);
    chk32("r_burst_data", bus.f_rdata, 32'hA000_0003);
    chk1("r_l_gnt", bus.l_gnt, 1'b1);
    chk1("r_l_we_off", bus.mem_we, 1'b0);
    @(negedge clk);
    bus.l_req = 1'b0;
    #1;
    chk1("r_l_rvalid", bus.l_rvalid, 1'b1);
    chk32("r_l_rdata", bus.l_rdata, 32'h1000_0003);
    chk1("r_f_rvalid_off", bus.f_rvalid, 1'b0);
    chk32("r_stall", bus.stall_cnt, 32'd9);

    // reset in the cycle after a fetch grant
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 8'd7;
    #1;
    chk1("x_f_gnt", bus.f_gnt, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
    #1;
    chk1("x_f_rvalid", bus.f_rvalid, 1'b0);
    chk1("x_f_gnt0", bus.f_gnt, 1'b0);
    chk1("x_l_gnt0", bus.l_gnt, 1'b0);
    chk1("x_mem_we0", bus.mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
    #1;
    chk1("x_post_f_rvalid", bus.f_rvalid, 1'b0);
    chk1("x_post_l_rvalid", bus.l_rvalid, 1'b0);
    chk32("x_post_stall", bus.stall_cnt, 32'd0);
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 8'd2;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_lock = 1'b1; bus.l_addr = 8'd4;
    #1;
    chk1("x_resume_f_gnt", bus.f_gnt, 1'b1);
    chk1("x_resume_l_gnt", bus.l_gnt, 1'b0);
    @(negedge clk);
    bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_lock = 1'b0;
    #1;
    chk1("x_resume_rvalid", bus.f_rvalid, 1'b1);
    chk32("x_resume_rdata", bus.f_rdata, 32'h1000_0002);
    chk32("x_resume_stall", bus.stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
